// File: rtl/rnr_rr_pipe.sv
// rnr_rr_pipe: pipeline register between Register Rename and Read Register.
// N-lane bundles move as a unit through a main register (M, drives outputs)
// and a skid register (S), so that in_ready can be a registered signal.
// Handshake: a bundle is accepted when |in_valid && in_ready, and handed off
// when |out_valid && out_ready; in_ready never depends on out_ready in the
// same cycle, and the head bundle is held stable while it is not taken.
// Optional feature macro: RNR_RR_BRMASK_EN adds per-lane branch masks with
// kill (selective squash) and resolve (mask bit clearing).
module rnr_rr_pipe #(
    parameter int LANES  = 2,
    parameter int CTRL_W = 165,
    parameter int PREG_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      recover,
    input  logic [LANES-1:0]          in_valid,
    output logic                      in_ready,
    input  logic [LANES*CTRL_W-1:0]   in_ctrl,
    input  logic [LANES*PREG_W-1:0]   in_rs,
    input  logic [LANES*PREG_W-1:0]   in_rt,
    input  logic [LANES*PREG_W-1:0]   in_rd,
    output logic [LANES-1:0]          out_valid,
    input  logic                      out_ready,
    output logic [LANES*CTRL_W-1:0]   out_ctrl,
    output logic [LANES*PREG_W-1:0]   out_rs,
    output logic [LANES*PREG_W-1:0]   out_rt,
    output logic [LANES*PREG_W-1:0]   out_rd,
`ifdef RNR_RR_BRMASK_EN
    input  logic [LANES*8-1:0]        in_brmask,
    output logic [LANES*8-1:0]        out_brmask,
    input  logic [7:0]                kill_mask,
    input  logic [7:0]                resolve_mask,
`endif
    output logic [15:0]               stall_cnt
);

    // One held bundle: per-lane valid vector plus every carried field.
    typedef struct packed {
        logic [LANES-1:0]        v;
        logic [LANES*CTRL_W-1:0] ctrl;
        logic [LANES*PREG_W-1:0] rs;
        logic [LANES*PREG_W-1:0] rt;
        logic [LANES*PREG_W-1:0] rd;
`ifdef RNR_RR_BRMASK_EN
        logic [LANES*8-1:0]      bm;
`endif
    } entry_t;

    entry_t m_q, s_q;       // registered main / skid entries
    entry_t in_raw;         // incoming bundle as presented
    entry_t in_e, m_e, s_e; // same three after this cycle's kill/resolve
    entry_t m_d, s_d;       // next-state values
    logic   in_fire, in_take, out_fire, m_vacate, s_has;

`ifdef RNR_RR_BRMASK_EN
    // Drop lanes depending on a killed branch and forget resolved branches.
    function automatic entry_t apply_masks(input entry_t e, input logic [7:0] kill,
                                           input logic [7:0] resolve);
        entry_t r;
        r = e;
        for (int i = 0; i < LANES; i++) begin
            if ((e.bm[i*8 +: 8] & kill) != 8'h00) r.v[i] = 1'b0;
            r.bm[i*8 +: 8] = e.bm[i*8 +: 8] & ~resolve;
        end
        return r;
    endfunction
`endif

    // Pack the input ports into an entry so all paths move whole bundles.
    always_comb begin
        in_raw      = '0;
        in_raw.v    = in_valid;
        in_raw.ctrl = in_ctrl;
        in_raw.rs   = in_rs;
        in_raw.rt   = in_rt;
        in_raw.rd   = in_rd;
`ifdef RNR_RR_BRMASK_EN
        in_raw.bm   = in_brmask;
`endif
    end

    // Apply this cycle's masks to held and incoming bundles.
    always_comb begin
`ifdef RNR_RR_BRMASK_EN
        in_e = apply_masks(in_raw, kill_mask, resolve_mask);
        m_e  = apply_masks(m_q, kill_mask, resolve_mask);
        s_e  = apply_masks(s_q, kill_mask, resolve_mask);
`else
        in_e = in_raw;
        m_e  = m_q;
        s_e  = s_q;
`endif
    end

    // Next-state selection for M and S. M "vacates" when its bundle is taken
    // or has no live lanes left; S then refills it, otherwise the input does.
    always_comb begin
        in_fire  = (|in_valid) & in_ready;
        in_take  = in_fire & (|in_e.v);
        out_fire = (|m_q.v) & out_ready;
        m_vacate = out_fire | ~(|m_e.v);
        s_has    = |s_e.v;
        m_d      = m_e;
        s_d      = s_e;
        if (m_vacate) begin
            s_d.v = '0;
            if (s_has) begin
                m_d = s_e;
            end else if (in_take) begin
                m_d = in_e;
            end else begin
                m_d.v = '0;
            end
        end else if (!s_has && in_take) begin
            s_d = in_e;
        end
    end

    // Entry registers and registered in_ready; reset beats recover beats transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q      <= '0;
            s_q      <= '0;
            in_ready <= 1'b1;
        end else if (recover) begin
            m_q.v    <= '0;
            s_q.v    <= '0;
            in_ready <= 1'b1;
        end else begin
            m_q      <= m_d;
            s_q      <= s_d;
            in_ready <= ~(|s_d.v);
        end
    end

    // Saturating count of cycles where a head bundle waits on the RR stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if ((|m_q.v) && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign out_valid = m_q.v;
    assign out_ctrl  = m_q.ctrl;
    assign out_rs    = m_q.rs;
    assign out_rt    = m_q.rt;
    assign out_rd    = m_q.rd;
`ifdef RNR_RR_BRMASK_EN
    assign out_brmask = m_q.bm;
`endif

endmodule

// File: tb/tb_rnr_rr_pipe.sv
// tb_rnr_rr_pipe: bench for rnr_rr_pipe. The reference is a bundle queue
// (head = outputs, capacity two), a ready flag and a saturating counter.
module tb_rnr_rr_pipe;
    localparam int LANES  = 2;
    localparam int CTRL_W = 165;
    localparam int PREG_W = 6;
    localparam int CW     = LANES*CTRL_W;
    localparam int PW     = LANES*PREG_W;

    logic             clk = 1'b0;
    logic             rst, recover, out_ready, in_ready;
    logic [LANES-1:0] in_valid, out_valid;
    logic [CW-1:0]    in_ctrl, out_ctrl;
    logic [PW-1:0]    in_rs, in_rt, in_rd, out_rs, out_rt, out_rd;
    logic [15:0]      stall_cnt;
`ifdef RNR_RR_BRMASK_EN
    logic [LANES*8-1:0] in_brmask, out_brmask;
    logic [7:0]         kill_mask, resolve_mask;
`endif

    typedef struct {
        logic [LANES-1:0] v;
        logic [CW-1:0]    ctrl;
        logic [PW-1:0]    rs, rt, rd;
    } bundle_t;

    bundle_t     exp_q[$];
    bit          m_rdy;
    int unsigned m_cnt;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    rnr_rr_pipe #(.LANES(LANES), .CTRL_W(CTRL_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .rst(rst), .recover(recover),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
`ifdef RNR_RR_BRMASK_EN
        .in_brmask(in_brmask), .out_brmask(out_brmask),
        .kill_mask(kill_mask), .resolve_mask(resolve_mask),
`endif
        .stall_cnt(stall_cnt)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: update on every rising edge from the sampled inputs
    always @(posedge clk) begin
        bundle_t b;
        if (rst) begin
            exp_q.delete();
            m_rdy = 1'b1;
            m_cnt = 0;
        end else begin
            if (exp_q.size() > 0 && !out_ready && m_cnt < 32'hFFFF) m_cnt++;
            if (recover) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
                if ((|in_valid) && m_rdy) begin
                    b.v = in_valid; b.ctrl = in_ctrl;
                    b.rs = in_rs; b.rt = in_rt; b.rd = in_rd;
                    exp_q.push_back(b);
                end
            end
            m_rdy = (exp_q.size() < 2);
        end
    end

    // scoreboard compare on every falling edge
    always @(negedge clk) begin
        logic [LANES-1:0] ev;
        if (chk_en) begin
            ev = (exp_q.size() > 0) ? exp_q[0].v : '0;
            chk("in_ready", in_ready, m_rdy);
            chk("out_valid", out_valid, ev);
            chk("stall_cnt", stall_cnt, m_cnt[15:0]);
            for (int i = 0; i < LANES; i++) begin
                if (ev[i]) begin
                    chk($sformatf("ctrl%0d", i), out_ctrl[i*CTRL_W +: CTRL_W], exp_q[0].ctrl[i*CTRL_W +: CTRL_W]);
                    chk($sformatf("rs%0d", i), out_rs[i*PREG_W +: PREG_W], exp_q[0].rs[i*PREG_W +: PREG_W]);
                    chk($sformatf("rt%0d", i), out_rt[i*PREG_W +: PREG_W], exp_q[0].rt[i*PREG_W +: PREG_W]);
                    chk($sformatf("rd%0d", i), out_rd[i*PREG_W +: PREG_W], exp_q[0].rd[i*PREG_W +: PREG_W]);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [LANES-1:0] v, input logic [PW-1:0] rs, input logic [PW-1:0] rd);
        logic [CW+31:0] t;
        for (int k = 0; k < CW; k += 32) t[k +: 32] = $urandom;
        in_valid = v;
        in_ctrl  = t[CW-1:0];
        in_rs    = rs;
        in_rt    = PW'($urandom);
        in_rd    = rd;
`ifdef RNR_RR_BRMASK_EN
        in_brmask = (LANES*8)'($urandom);
`endif
    endtask

    task automatic drive_rand(input int rdy_pct);
        send(LANES'($urandom_range(0, (1 << LANES) - 1)), PW'($urandom), PW'($urandom));
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        recover   = ($urandom_range(0, 40) == 0);
    endtask

    task automatic idle_in();
        in_valid = '0;
        recover  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; recover = 1'b0; out_ready = 1'b0;
        in_valid = '0; in_ctrl = '0; in_rs = '0; in_rt = '0; in_rd = '0;
`ifdef RNR_RR_BRMASK_EN
        in_brmask = '0; kill_mask = '0; resolve_mask = '0;
`endif
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 2'b00);
        chk("rst_stall", stall_cnt, 16'h0);

        // single bundle, immediate hand-off
        out_ready = 1'b1;
        send(2'b11, '0, {6'd11, 6'd10});
        step();
        chk("t1_valid", out_valid, 2'b11);
        chk("t1_rd0", out_rd[5:0], 6'd10);
        chk("t1_rd1", out_rd[11:6], 6'd11);
        chk("t1_ready", in_ready, 1'b1);
        idle_in();
        step();

        // fill M then S with the consumer blocked, then drain in order
        out_ready = 1'b0;
        send(2'b11, '0, {6'd21, 6'd20});
        step();
        chk("t2_ready_a", in_ready, 1'b1);
        send(2'b11, '0, {6'd31, 6'd30});
        step();
        chk("t2_ready_b", in_ready, 1'b0);
        chk("t2_hold_rd0", out_rd[5:0], 6'd20);
        idle_in();
        step();
        chk("t2_stable_rd1", out_rd[11:6], 6'd21);
        out_ready = 1'b1;
        step();
        chk("t2_b_rd0", out_rd[5:0], 6'd30);
        chk("t2_ready_c", in_ready, 1'b1);
        step();
        chk("t2_empty", out_valid, 2'b00);

        // recover with both entries full drops everything, including new input
        out_ready = 1'b0;
        send(2'b11, '0, '0); step();
        send(2'b11, '0, '0); step();
        send(2'b01, '0, {6'd0, 6'd5});
        recover = 1'b1;
        step();
        chk("t3_valid", out_valid, 2'b00);
        chk("t3_ready", in_ready, 1'b1);
        idle_in();
        step();
        chk("t3_still_empty", out_valid, 2'b00);

        // lane 1 only
        out_ready = 1'b1;
        send(2'b10, {6'd33, 6'd0}, '0);
        step();
        chk("t4_valid", out_valid, 2'b10);
        chk("t4_rs1", out_rs[11:6], 6'd33);
        idle_in();
        step();

        // randomized traffic with varying back-pressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 800; c++) begin
                drive_rand(ph * 30 + 10);
                step();
            end
        end
        idle_in();

        // reset while both entries are full
        out_ready = 1'b0;
        send(2'b11, '0, '0); step();
        send(2'b11, '0, '0); step();
        idle_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", out_valid, 2'b00);
        chk("t6_ready", in_ready, 1'b1);
        chk("t6_stall", stall_cnt, 16'h0);

        // long stall saturates the counter
        send(2'b01, '0, '0); step();
        idle_in();
        repeat (70000) step();
        chk("t5_sat", stall_cnt, 16'hFFFF);
        step();
        chk("t5_nowrap", stall_cnt, 16'hFFFF);
        out_ready = 1'b1;
        repeat (3) step();

`ifdef RNR_RR_BRMASK_EN
        // selective kill and resolve (model does not track branch masks)
        chk_en = 1'b0;
        out_ready = 1'b0;
        send(2'b11, '0, '0);
        in_brmask = {8'h02, 8'h01};
        step();
        idle_in();
        chk("bm_valid0", out_valid, 2'b11);
        kill_mask = 8'h02;
        step();
        kill_mask = 8'h00;
        chk("bm_kill", out_valid, 2'b01);
        resolve_mask = 8'h01;
        step();
        resolve_mask = 8'h00;
        chk("bm_resolve", out_brmask[7:0], 8'h00);
        chk("bm_keep", out_valid, 2'b01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rnr_rr_pipe.md
Name: rnr_rr_pipe

Overview:
- Parametrised N-lane pipeline register between the Register Rename and Read Register stages.
- Carries per-lane control payload plus rs/rt/rd physical register numbers.
- Replaces the fixed 2-lane stall-enable register with a valid/ready handshake, a 2-entry skid buffer (registered in_ready), per-lane valid bits and recover flush.
- Bundles move as a unit; order is preserved.

Parameters:
LANES, 2, instructions per bundle (1..4)
CTRL_W, 165, per-lane control payload width
PREG_W, 6, physical register number width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
recover  in  1  mispredict/exception recovery; flushes all held bundles
in_valid  in  LANES  per-lane valid of incoming bundle; bit i = lane i
in_ready  out  1  block can accept a bundle this cycle (registered)
in_ctrl  in  LANES*CTRL_W  lane i at [i*CTRL_W +: CTRL_W]
in_rs  in  LANES*PREG_W  rs physical numbers, same packing
in_rt  in  LANES*PREG_W  rt physical numbers
in_rd  in  LANES*PREG_W  destination physical numbers
out_valid  out  LANES  per-lane valid of head bundle
out_ready  in  1  RR stage accepts head bundle
out_ctrl, out_rs, out_rt, out_rd  out  as inputs  head bundle fields
stall_cnt  out  16  saturating count of cycles with out_valid!=0 and out_ready=0

Behaviour:
- Storage: main register M (drives outputs) and skid register S; each holds valid vector plus all fields.
- Bundle present = |valid. Lanes with valid=0 carry don't-care fields.
- Accept: in_fire = |in_valid & in_ready. Drain: out_fire = |out_valid & out_ready.
- Input with in_valid=0 is ignored and never occupies an entry.
- Latency: accepted bundle appears on outputs the next cycle when M is empty or draining.
- in_ready = ~S.valid_any, registered; never combinationally depends on out_ready.
- Transitions per edge (recover=0):
  - M empty, in_fire: M <- input.
  - M full, out_fire, S empty: M <- input if in_fire, else M cleared.
  - M full, out_fire, S full: M <- S, S cleared. No in_fire is possible since in_ready=0.
  - M full, no out_fire, in_fire: S <- input. in_ready drops next cycle.
  - M full, no out_fire, no in_fire: hold.
- Outputs are stable while out_valid!=0 and out_ready=0.
- recover=1 clears M and S valid vectors next edge; input in the same cycle is dropped; in_ready=1 next cycle. recover has priority over all transfers. stall_cnt is unaffected.
- rst=1: all valid bits 0, all fields 0, in_ready=1, stall_cnt=0 next edge. Reset overrides recover. Reset mid-stall discards both entries.
- stall_cnt saturates at 16'hFFFF, no wrap.

Optional Feature:
Macro RNR_RR_BRMASK_EN.
- Defined:
  - Adds in_brmask (in, LANES*8) and out_brmask (out, LANES*8), carried per lane like the other fields.
  - Adds kill_mask (in, 8) and resolve_mask (in, 8).
  - Each edge, any held lane whose brmask AND kill_mask != 0 has its valid cleared.
  - resolve_mask bits are cleared from all held brmasks.
  - Both masks apply to the incoming bundle in the same cycle it is captured.
  - A bundle whose lanes are all killed frees its entry (S empties; M refills from S).
  - recover still flushes everything.
- Not defined: ports absent, no selective squash.

Test Plan:
- Reset, then in_valid=2'b11, rd=6'd10/6'd11, out_ready=1 -> out_valid=2'b11 one cycle later with rd 10/11; in_ready stays 1.
- out_ready=0, send bundles A then B -> A on outputs, B in S, in_ready=0 on 3rd cycle, A held stable. Raise out_ready -> A, then B, drained in order; in_ready=1 again.
- S and M full, recover=1 with new in_valid=2'b01 -> next cycle out_valid=0, in_ready=1, dropped bundle never appears.
- in_valid=2'b10 only, lane1 rs=6'd33 -> out_valid=2'b10, out_rs lane1=33.
- out_valid!=0 held with out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF.
- BRMASK_EN: lane0 brmask=8'h01, lane1 brmask=8'h02 held; kill_mask=8'h02 -> out_valid=2'b01. resolve_mask=8'h01 -> lane0 out_brmask=0.
